lsu_access_sequencer: RTL and testbench

- Load/store sequencer between the pipeline memory stage and the byte-addressed data memory; drives that memory's address/data_in/w_enable/access_size/RdUn inputs and consumes its data_out.
- Accepts one load/store request at a time and range-checks it.
- Aligned accesses go to memory as one operation. Misaligned halfword/word accesses are split into sequential byte operations and reassembled.
- Returns a single-cycle response with extended load data or a fault flag.

---
 rtl/lsu_access_sequencer_pkg.sv | 27 ++
 rtl/lsu_access_sequencer_load_extend.sv | 20 ++
 rtl/lsu_access_sequencer.sv | 164 ++++++++++++++++
 tb/tb_lsu_access_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_access_sequencer_pkg.sv
// Shared definitions for the load/store sequencer: access-size codes, fault
// read value and FSM state encoding.
package lsu_access_sequencer_pkg;

    localparam logic [1:0] BYTE     = 2'b00;
    localparam logic [1:0] HALFWORD = 2'b01;
    localparam logic [1:0] WORD     = 2'b10;

    localparam logic [31:0] FAULT_RDATA = 32'hBADBADFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SINGLE = 2'b01,
        ST_SPLIT  = 2'b10,
        ST_RESP   = 2'b11
    } lsu_state_t;

    // Reserved size code 2'b11 maps to 4 bytes; it is faulted before use.
    function automatic logic [2:0] size_nbytes(input logic [1:0] size);
        case (size)
            BYTE:     size_nbytes = 3'd1;
            HALFWORD: size_nbytes = 3'd2;
            default:  size_nbytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_access_sequencer_load_extend.sv
// Sign/zero extension of a raw load value to 32 bits; also used by writeback.
module load_extend
    import lsu_access_sequencer_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            BYTE:     ext = is_unsigned ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            HALFWORD: ext = is_unsigned ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default:  ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_access_sequencer.sv
// Load/store sequencer: range-checks one request at a time, issues aligned
// accesses directly and splits misaligned ones into byte operations.
//
// state  | meaning
// IDLE   | ready for a request; memory idle
// SINGLE | one aligned memory operation
// SPLIT  | byte operation number `count` of a misaligned access
// RESP   | one-cycle response (data, zero for stores, or fault)
module lsu_access_sequencer
    import lsu_access_sequencer_pkg::*;
#(
    parameter logic [31:0] START_ADDR       = 32'h0100_0000,
    parameter logic [31:0] MEM_SIZE         = 32'h0010_0000,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_w_enable,
    output logic [1:0]  mem_access_size,
    output logic        mem_RdUn,
    input  logic [31:0] mem_data_out
);

    localparam logic [32:0] REGION_END = {1'b0, START_ADDR} + {1'b0, MEM_SIZE};

    lsu_state_t  state, state_nxt;
    logic [1:0]  count;
    logic [31:0] rbuf;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_unsigned;
    logic        lat_fault;

    logic [2:0]  req_nbytes;
    logic [32:0] req_end;
    logic        req_misaligned;
    logic        req_fault;
    logic [2:0]  lat_nbytes;
    logic        split_last;
    logic [31:0] rbuf_ext;
    logic        accept;

    // End address in 33 bits so a request wrapping past 2^32 lands out of range.
    always_comb begin
        req_nbytes     = size_nbytes(req_size);
        req_end        = {1'b0, req_addr} + 33'(req_nbytes);
        req_misaligned = ((req_size == HALFWORD) && req_addr[0]) ||
                         ((req_size == WORD) && (req_addr[1:0] != 2'b00));
        req_fault      = (req_size == 2'b11) ||
                         (req_addr < START_ADDR) ||
                         (req_end > REGION_END) ||
                         (req_misaligned && !ALLOW_MISALIGNED);
        lat_nbytes     = size_nbytes(lat_size);
        split_last     = ({1'b0, count} == (lat_nbytes - 3'd1));
        accept         = (state == ST_IDLE) && req_valid;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_fault)           state_nxt = ST_RESP;
                    else if (req_misaligned) state_nxt = ST_SPLIT;
                    else                     state_nxt = ST_SINGLE;
                end
            end
            ST_SINGLE: state_nxt = ST_RESP;
            ST_SPLIT:  if (split_last) state_nxt = ST_RESP;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            count        <= 2'd0;
            rbuf         <= 32'd0;
            lat_write    <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            lat_size     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_fault    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lat_write    <= req_write;
                lat_addr     <= req_addr;
                lat_wdata    <= req_wdata;
                lat_size     <= req_size;
                lat_unsigned <= req_unsigned;
                lat_fault    <= req_fault;
                count        <= 2'd0;
                rbuf         <= 32'd0;
            end else if (state == ST_SINGLE) begin
                if (!lat_write) rbuf <= mem_data_out;
            end else if (state == ST_SPLIT) begin
                if (!lat_write) rbuf[{count, 3'b000} +: 8] <= mem_data_out[7:0];
                count <= count + 2'd1;
            end
        end
    end

    // Single loads come back already extended by the memory; re-extending is harmless.
    load_extend u_load_extend (
        .size        (lat_size),
        .is_unsigned (lat_unsigned),
        .raw         (rbuf),
        .ext         (rbuf_ext)
    );

    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = 32'd0;
        resp_fault      = 1'b0;
        mem_address     = lat_addr;
        mem_data_in     = 32'd0;
        mem_w_enable    = 1'b0;
        mem_access_size = WORD;
        mem_RdUn        = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_SINGLE: begin
                mem_access_size = lat_size;
                mem_RdUn        = lat_unsigned;
                mem_data_in     = lat_wdata;
                mem_w_enable    = lat_write;
            end
            ST_SPLIT: begin
                mem_address     = lat_addr + {30'd0, count};
                mem_access_size = BYTE;
                mem_RdUn        = 1'b1;
                mem_data_in     = {24'd0, lat_wdata[{count, 3'b000} +: 8]};
                mem_w_enable    = lat_write;
            end
            default: begin
                resp_valid = 1'b1;
                if (lat_fault) begin
                    resp_rdata = FAULT_RDATA;
                    resp_fault = 1'b1;
                end else if (!lat_write) begin
                    resp_rdata = rbuf_ext;
                end
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_access_sequencer.sv
// Directed bench for lsu_access_sequencer with a small byte-addressed memory model.
module tb_lsu_access_sequencer;
    import lsu_access_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;

    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_fault;
    logic [31:0] resp_rdata;
    logic [31:0] mem_address, mem_data_in, mem_data_out;
    logic        mem_w_enable, mem_RdUn;
    logic [1:0]  mem_access_size;

    logic        b_req_valid, b_req_ready, b_req_write, b_req_unsigned;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [1:0]  b_req_size;
    logic        b_resp_valid, b_resp_fault;
    logic [31:0] b_resp_rdata;
    logic [31:0] b_mem_address, b_mem_data_in, b_mem_data_out;
    logic        b_mem_w_enable, b_mem_RdUn;
    logic [1:0]  b_mem_access_size;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:4095];

    always #5 clk = ~clk;

    lsu_access_sequencer dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
        .req_unsigned(req_unsigned),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_w_enable(mem_w_enable), .mem_access_size(mem_access_size),
        .mem_RdUn(mem_RdUn), .mem_data_out(mem_data_out)
    );

    lsu_access_sequencer #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_size(b_req_size),
        .req_unsigned(b_req_unsigned),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_fault(b_resp_fault),
        .mem_address(b_mem_address), .mem_data_in(b_mem_data_in),
        .mem_w_enable(b_mem_w_enable), .mem_access_size(b_mem_access_size),
        .mem_RdUn(b_mem_RdUn), .mem_data_out(b_mem_data_out)
    );

    // Memory model: little-endian, combinational read, extension done in memory.
    function automatic logic [31:0] assemble(input logic [7:0] b0, input logic [7:0] b1,
                                             input logic [7:0] b2, input logic [7:0] b3,
                                             input logic [1:0] size, input logic rdun);
        case (size)
            BYTE:     assemble = rdun ? {24'd0, b0} : {{24{b0[7]}}, b0};
            HALFWORD: assemble = rdun ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default:  assemble = {b3, b2, b1, b0};
        endcase
    endfunction

    logic [11:0] a0, a1, a2, a3, ba0, ba1, ba2, ba3;
    assign a0  = mem_address[11:0];
    assign a1  = a0 + 12'd1;
    assign a2  = a0 + 12'd2;
    assign a3  = a0 + 12'd3;
    assign ba0 = b_mem_address[11:0];
    assign ba1 = ba0 + 12'd1;
    assign ba2 = ba0 + 12'd2;
    assign ba3 = ba0 + 12'd3;
    assign mem_data_out   = assemble(mem[a0], mem[a1], mem[a2], mem[a3],
                                     mem_access_size, mem_RdUn);
    assign b_mem_data_out = assemble(mem[ba0], mem[ba1], mem[ba2], mem[ba3],
                                     b_mem_access_size, b_mem_RdUn);

    always @(posedge clk) begin
        if (mem_w_enable) begin
            mem[a0] <= mem_data_in[7:0];
            if (mem_access_size != BYTE) mem[a1] <= mem_data_in[15:8];
            if (mem_access_size == WORD) begin
                mem[a2] <= mem_data_in[23:16];
                mem[a3] <= mem_data_in[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the main instance and check latency, data, fault and write cycles.
    task automatic do_req(input string tag, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          input int exp_lat, input logic [31:0] exp_rdata,
                          input logic exp_fault, input int exp_we);
        int lat;
        int we_cycles;
        chk({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
        req_size = size; req_unsigned = uns;
        tick;
        req_valid = 1'b0;
        lat = 1;
        we_cycles = 0;
        while (!resp_valid && lat < 12) begin
            if (mem_w_enable) we_cycles++;
            tick;
            lat++;
        end
        if (mem_w_enable) we_cycles++;
        chk({tag, "_lat"},   32'(lat),        32'(exp_lat));
        chk({tag, "_rdata"}, resp_rdata,      exp_rdata);
        chk({tag, "_fault"}, 32'(resp_fault), 32'(exp_fault));
        chk({tag, "_we"},    32'(we_cycles),  32'(exp_we));
        tick;
    endtask

    initial begin
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_unsigned = 0;
        b_req_valid = 0; b_req_write = 0; b_req_addr = 0; b_req_wdata = 0; b_req_size = 0;
        b_req_unsigned = 0;
        #2;
        chk("rst_ready",    32'(req_ready),       32'd1);
        chk("rst_resp_v",   32'(resp_valid),      32'd0);
        chk("rst_fault",    32'(resp_fault),      32'd0);
        chk("rst_we",       32'(mem_w_enable),    32'd0);
        chk("rst_addr",     mem_address,          32'd0);
        chk("rst_size",     32'(mem_access_size), 32'(WORD));
        chk("rst_rdun",     32'(mem_RdUn),        32'd0);
        chk("rst_din",      mem_data_in,          32'd0);
        chk("rst_rdata",    resp_rdata,           32'd0);
        tick; tick;
        reset_n = 1'b1;
        tick;

        do_req("pre_w0",   1, 32'h0100_0000, 32'h0000_0513, WORD, 0, 2, 32'd0, 0, 1);
        do_req("ld_w0",    0, 32'h0100_0000, 32'd0,         WORD, 0, 2, 32'h0000_0513, 0, 0);
        do_req("pre_b100", 1, 32'h0100_0100, 32'h0000_005A, BYTE, 0, 2, 32'd0, 0, 1);
        do_req("st_split", 1, 32'h0100_0101, 32'hA1B2_C3D4, WORD, 0, 5, 32'd0, 0, 4);
        do_req("ld_b101",  0, 32'h0100_0101, 32'd0, BYTE, 1, 2, 32'h0000_00D4, 0, 0);
        do_req("ld_b102",  0, 32'h0100_0102, 32'd0, BYTE, 1, 2, 32'h0000_00C3, 0, 0);
        do_req("ld_b103",  0, 32'h0100_0103, 32'd0, BYTE, 1, 2, 32'h0000_00B2, 0, 0);
        do_req("ld_b104",  0, 32'h0100_0104, 32'd0, BYTE, 1, 2, 32'h0000_00A1, 0, 0);
        do_req("ld_w100",  0, 32'h0100_0100, 32'd0, WORD, 0, 2, 32'hB2C3_D45A, 0, 0);
        do_req("ld_split", 0, 32'h0100_0101, 32'd0, WORD, 0, 5, 32'hA1B2_C3D4, 0, 0);

        do_req("pre_b003", 1, 32'h0100_0003, 32'h0000_0080, BYTE, 0, 2, 32'd0, 0, 1);
        do_req("pre_b004", 1, 32'h0100_0004, 32'h0000_00FF, BYTE, 0, 2, 32'd0, 0, 1);
        do_req("ld_h003s", 0, 32'h0100_0003, 32'd0, HALFWORD, 0, 3, 32'hFFFF_FF80, 0, 0);
        do_req("ld_h003u", 0, 32'h0100_0003, 32'd0, HALFWORD, 1, 3, 32'h0000_FF80, 0, 0);
        do_req("ld_b003s", 0, 32'h0100_0003, 32'd0, BYTE,     0, 2, 32'hFFFF_FF80, 0, 0);

        do_req("flt_top",  0, 32'h010F_FFFE, 32'd0,  WORD, 0, 1, FAULT_RDATA, 1, 0);
        do_req("flt_wrap", 1, 32'hFFFF_FFFE, 32'h1234_5678, WORD, 0, 1, FAULT_RDATA, 1, 0);
        do_req("flt_low",  1, 32'h00FF_FFFF, 32'h55, BYTE, 0, 1, FAULT_RDATA, 1, 0);
        do_req("flt_size", 1, 32'h0100_0000, 32'h55, 2'b11, 0, 1, FAULT_RDATA, 1, 0);
        do_req("st_last",  1, 32'h010F_FFFF, 32'h77, BYTE, 0, 2, 32'd0, 0, 1);
        do_req("ld_last",  0, 32'h010F_FFFF, 32'd0,  BYTE, 1, 2, 32'h0000_0077, 0, 0);
        do_req("ld_w0b",   0, 32'h0100_0000, 32'd0,  WORD, 0, 2, 32'h8000_0513, 0, 0);

        // Reset during the second byte of a split store.
        do_req("pre_w200", 1, 32'h0100_0200, 32'd0, WORD, 0, 2, 32'd0, 0, 1);
        do_req("pre_w204", 1, 32'h0100_0204, 32'd0, WORD, 0, 2, 32'd0, 0, 1);
        req_valid = 1; req_write = 1; req_addr = 32'h0100_0201; req_wdata = 32'h1122_3344;
        req_size = WORD; req_unsigned = 0;
        tick;
        req_valid = 0;
        chk("rs_we1", 32'(mem_w_enable), 32'd1);
        tick;
        chk("rs_we2", 32'(mem_w_enable), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rs_we_drop", 32'(mem_w_enable), 32'd0);
        chk("rs_ready",   32'(req_ready),    32'd1);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rs_no_resp", 32'(resp_valid), 32'd0);
        end
        reset_n = 1'b1;
        tick;
        chk("rs_no_resp_after", 32'(resp_valid), 32'd0);
        do_req("rs_b201", 0, 32'h0100_0201, 32'd0, BYTE, 1, 2, 32'h0000_0044, 0, 0);
        do_req("rs_h202", 0, 32'h0100_0202, 32'd0, HALFWORD, 1, 2, 32'd0, 0, 0);
        do_req("rs_w204", 0, 32'h0100_0204, 32'd0, WORD, 0, 2, 32'd0, 0, 0);

        // Strict instance: misaligned faults, held request not re-accepted mid-operation.
        chk("b_ready0", 32'(b_req_ready), 32'd1);
        b_req_valid = 1; b_req_addr = 32'h0100_0001; b_req_size = HALFWORD;
        tick;
        b_req_valid = 0;
        chk("b_mis_valid", 32'(b_resp_valid), 32'd1);
        chk("b_mis_fault", 32'(b_resp_fault), 32'd1);
        chk("b_mis_rdata", b_resp_rdata,      FAULT_RDATA);
        tick;
        b_req_valid = 1; b_req_addr = 32'h0100_0000; b_req_size = WORD;
        chk("b_idle_ready", 32'(b_req_ready), 32'd1);
        tick;
        chk("b_single_ready", 32'(b_req_ready),  32'd0);
        chk("b_single_resp",  32'(b_resp_valid), 32'd0);
        tick;
        chk("b_resp_ready", 32'(b_req_ready),  32'd0);
        chk("b_resp_valid", 32'(b_resp_valid), 32'd1);
        chk("b_resp_rdata", b_resp_rdata,      32'h8000_0513);
        chk("b_resp_fault", 32'(b_resp_fault), 32'd0);
        tick;
        chk("b_idle2_ready", 32'(b_req_ready),  32'd1);
        chk("b_idle2_resp",  32'(b_resp_valid), 32'd0);
        tick;
        b_req_valid = 0;
        chk("b_reaccept", 32'(b_req_ready), 32'd0);
        tick;
        chk("b_resp2", 32'(b_resp_valid), 32'd1);
        chk("b_we_never", 32'(b_mem_w_enable), 32'd0);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
